// File: rtl/utils_pkg.sv
// Shared encodings for the memory requester: access widths, write/read
// strobe polarity, exception codes, FSM states and request classification.
package utils_pkg;

    localparam int DATA_WIDTH = 64;

    // Access width encodings on req_wid_i / mem_wid_o
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_D  = 3'b011;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [2:0] MEM_WU = 3'b110;

    // mem_enwr_o polarity
    localparam logic MEM_WRITE = 1'b0;
    localparam logic MEM_READ  = 1'b1;

    typedef enum logic [1:0] {
        EXC_NONE         = 2'b00,
        EXC_MISALIGNED   = 2'b01,
        EXC_ACCESS_FAULT = 2'b10,
        EXC_ILLEGAL      = 2'b11
    } exc_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_e;

    // Classify a request at acceptance: illegal beats misaligned beats
    // out-of-range. Unsigned variants share the alignment rule of their width.
    function automatic exc_e classify(input logic       we,
                                      input logic [2:0] wid,
                                      input logic [2:0] addr_lo,
                                      input logic       out_of_range);
        logic illegal;
        logic misaligned;
        illegal = (wid == 3'b111) ||
                  (we && (wid == MEM_BU || wid == MEM_HU || wid == MEM_WU));
        case (wid)
            MEM_H, MEM_HU: misaligned = addr_lo[0];
            MEM_W, MEM_WU: misaligned = |addr_lo[1:0];
            MEM_D:         misaligned = |addr_lo;
            default:       misaligned = 1'b0;
        endcase
        if (illegal)
            return EXC_ILLEGAL;
        else if (misaligned)
            return EXC_MISALIGNED;
        else if (out_of_range)
            return EXC_ACCESS_FAULT;
        else
            return EXC_NONE;
    endfunction

endpackage

// File: rtl/mem_requester_if.sv
// Pipeline request/response handshake plus the memory-side strobe bus of the
// requester. 'slave' is the requester's view, 'master' is the pipeline/memory view.
interface mem_requester_if
    import utils_pkg::*;
#(
    parameter int RAM_SIZE = 16
);
    // Pipeline request
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [2:0]            req_wid_i;
    logic [63:0]           req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    // Pipeline response
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    exc_e                  rsp_exc_o;
    // Memory side
    logic [RAM_SIZE-1:0]   mem_addr_o;
    logic                  mem_enwr_o;
    logic                  mem_en_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic [2:0]            mem_wid_o;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic                  mem_unalign_i;

    modport slave (
        input  req_valid_i, req_we_i, req_wid_i, req_addr_i, req_wdata_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_exc_o,
        input  rsp_ready_i,
        output mem_addr_o, mem_enwr_o, mem_en_o, mem_data_o, mem_wid_o,
        input  mem_data_i, mem_unalign_i
    );

    modport master (
        output req_valid_i, req_we_i, req_wid_i, req_addr_i, req_wdata_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_exc_o,
        output rsp_ready_i,
        input  mem_addr_o, mem_enwr_o, mem_en_o, mem_data_o, mem_wid_o,
        output mem_data_i, mem_unalign_i
    );

endinterface

// File: rtl/mem_requester.sv
// Single-outstanding memory requester: accepts one load/store from the
// pipeline, checks it, strobes the memory for one cycle and returns one
// response. Sign/zero extension of load data is done by the memory.
module mem_requester
    import utils_pkg::*;
#(
    parameter int RAM_SIZE = 16
) (
    input  logic            clk,
    input  logic            rst,
    mem_requester_if.slave  bus
);

    state_e                state_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    exc_e                  rsp_exc_q;
    logic                  mem_en_q;
    logic                  mem_enwr_q;
    logic [RAM_SIZE-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [2:0]            mem_wid_q;
    logic                  we_q;

    logic                  out_of_range;
    exc_e                  acc_exc;

    // Any address bit above the RAM window makes the access unreachable
    assign out_of_range = |(bus.req_addr_i >> RAM_SIZE);

    // Exception class of the request currently offered at the input
    always_comb begin
        acc_exc = classify(bus.req_we_i, bus.req_wid_i, bus.req_addr_i[2:0],
                           out_of_range);
    end

    // Request FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_exc_q   <= EXC_NONE;
            mem_en_q    <= 1'b0;
            mem_enwr_q  <= MEM_READ;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_wid_q   <= MEM_B;
            we_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        we_q        <= bus.req_we_i;
                        rsp_rdata_q <= '0;
                        if (acc_exc != EXC_NONE) begin
                            // Rejected requests never reach the memory
                            rsp_exc_q   <= acc_exc;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            rsp_exc_q  <= EXC_NONE;
                            mem_en_q   <= 1'b1;
                            mem_enwr_q <= ~bus.req_we_i;
                            mem_addr_q <= bus.req_addr_i[RAM_SIZE-1:0];
                            mem_wid_q  <= bus.req_wid_i;
                            mem_data_q <= bus.req_wdata_i;
                            state_q    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The strobe lasts exactly this one cycle
                    mem_en_q <= 1'b0;
                    if (bus.mem_unalign_i)
                        rsp_exc_q <= EXC_ACCESS_FAULT;
                    if (we_q) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // A faulted load returns zero instead of memory data
                    rsp_rdata_q <= (rsp_exc_q == EXC_NONE) ? bus.mem_data_i : '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_exc_o   = rsp_exc_q;
    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_enwr_o  = mem_enwr_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_data_o  = mem_data_q;
    assign bus.mem_wid_o   = mem_wid_q;

endmodule

// File: tb/tb_mem_requester.sv
// Scoreboard bench for mem_requester with a byte-array memory model that
// performs the width extension.
module tb_mem_requester;
    import utils_pkg::*;

    localparam int RAM_SIZE = 16;
    localparam int MEM_BYTES = 1 << RAM_SIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_requester_if #(.RAM_SIZE(RAM_SIZE)) bus ();

    mem_requester #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- memory model ----------------
    logic [7:0]  mem [0:MEM_BYTES-1];
    logic [63:0] mem_rdata = '0;
    logic        preload = 1'b0;
    logic        force_unalign = 1'b0;

    assign bus.mem_data_i    = mem_rdata;
    assign bus.mem_unalign_i = force_unalign;

    function automatic int nbytes(input logic [2:0] w);
        case (w)
            MEM_B, MEM_BU: return 1;
            MEM_H, MEM_HU: return 2;
            MEM_W, MEM_WU: return 4;
            default:       return 8;
        endcase
    endfunction

    function automatic logic [63:0] rd_ext(input int a, input logic [2:0] w);
        logic [63:0] raw;
        raw = '0;
        for (int i = 0; i < 8; i++)
            if (a + i < MEM_BYTES) raw[8*i +: 8] = mem[a + i];
        case (w)
            MEM_B:   return {{56{raw[7]}}, raw[7:0]};
            MEM_H:   return {{48{raw[15]}}, raw[15:0]};
            MEM_W:   return {{32{raw[31]}}, raw[31:0]};
            MEM_D:   return raw;
            MEM_BU:  return {56'b0, raw[7:0]};
            MEM_HU:  return {48'b0, raw[15:0]};
            MEM_WU:  return {32'b0, raw[31:0]};
            default: return '0;
        endcase
    endfunction

    // Synchronous memory: write or registered extended read on the strobe
    always @(posedge clk) begin
        if (preload) mem[16'h0100] <= 8'h80;
        if (bus.mem_en_o) begin
            if (bus.mem_enwr_o == MEM_WRITE) begin
                for (int i = 0; i < 8; i++)
                    if (i < nbytes(bus.mem_wid_o) && int'(bus.mem_addr_o) + i < MEM_BYTES)
                        mem[int'(bus.mem_addr_o) + i] <= bus.mem_data_o[8*i +: 8];
            end else begin
                mem_rdata <= rd_ext(int'(bus.mem_addr_o), bus.mem_wid_o);
            end
        end
    end

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] rdata;
        exc_e        exc;
        int          lat;
        int          en;
        int          t;
        int          en_base;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   en_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one request (called just after a rising edge); optionally log
    // the expected response in the scoreboard.
    task automatic send(input logic we, input logic [2:0] wid, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] erd, input exc_e eexc,
                        input int lat, input int en, input bit push);
        int waited;
        exp_t e;
        waited = 0;
        while (!bus.req_ready_o && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.req_ready_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_ready_timeout: req_ready_o stayed 0 for 50 cycles, required 1");
            return;
        end
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_wid_i   = wid;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        if (push) begin
            e = '{rdata: erd, exc: eexc, lat: lat, en: en, t: cyc, en_base: en_cnt};
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit   in_rsp;
        int   first_cyc;
        exp_t e;
        in_rsp = 0;
        first_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_rsp = 0;
            end else begin
                if (bus.mem_en_o) en_cnt++;
                if (bus.rsp_valid_o) begin
                    if (!in_rsp) begin
                        in_rsp = 1;
                        first_cyc = cyc;
                    end
                    if (bus.rsp_ready_i) begin
                        in_rsp = 0;
                        if (sbq.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexpected_rsp: rsp_valid_o=1 with nothing outstanding, required 0");
                        end else begin
                            e = sbq.pop_front();
                            chk("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                            chk("rsp_exc", 64'(bus.rsp_exc_o), 64'(e.exc));
                            chk("rsp_latency", 64'(first_cyc - e.t), 64'(e.lat));
                            chk("mem_en_cycles", 64'(en_cnt - e.en_base), 64'(e.en));
                        end
                    end
                end else begin
                    in_rsp = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_wid_i   = MEM_B;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b1;
        rst = 1'b1;
        preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        preload = 1'b0;

        // Reset values
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 64'd0);
        chk("rst_rsp_exc", 64'(bus.rsp_exc_o), 64'(EXC_NONE));
        chk("rst_mem_en", 64'(bus.mem_en_o), 64'd0);
        chk("rst_mem_enwr", 64'(bus.mem_enwr_o), 64'd1);
        chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        chk("rst_mem_data", bus.mem_data_o, 64'd0);
        chk("rst_mem_wid", 64'(bus.mem_wid_o), 64'd0);

        // Directed vectors: we, wid, addr, wdata, rdata, exc, latency, strobes
        send(0, MEM_B,  64'h100,   64'h0, 64'hFFFF_FFFF_FFFF_FF80, EXC_NONE, 3, 1, 1);
        send(1, MEM_D,  64'h200,   64'h1122_3344_5566_7788, 64'h0, EXC_NONE, 2, 1, 1);
        send(0, MEM_D,  64'h200,   64'h0, 64'h1122_3344_5566_7788, EXC_NONE, 3, 1, 1);
        send(0, MEM_W,  64'h102,   64'h0, 64'h0, EXC_MISALIGNED, 1, 0, 1);
        send(1, MEM_HU, 64'h200,   64'h0, 64'h0, EXC_ILLEGAL, 1, 0, 1);
        send(0, MEM_B,  64'h1_0000, 64'h0, 64'h0, EXC_ACCESS_FAULT, 1, 0, 1);
        send(0, 3'b111, 64'h201,   64'h0, 64'h0, EXC_ILLEGAL, 1, 0, 1);
        send(0, MEM_BU, 64'h203,   64'h0, 64'h55, EXC_NONE, 3, 1, 1);
        send(0, MEM_HU, 64'h206,   64'h0, 64'h1122, EXC_NONE, 3, 1, 1);
        send(0, MEM_W,  64'h204,   64'h0, 64'h0000_0000_1122_3344, EXC_NONE, 3, 1, 1);
        send(1, MEM_H,  64'h300,   64'hFFFF_0000_0000_8001, 64'h0, EXC_NONE, 2, 1, 1);
        send(0, MEM_H,  64'h300,   64'h0, 64'hFFFF_FFFF_FFFF_8001, EXC_NONE, 3, 1, 1);
        send(1, MEM_D,  64'h204,   64'h0, 64'h0, EXC_MISALIGNED, 1, 0, 1);

        // Memory reports misalignment during the strobe
        force_unalign = 1'b1;
        send(0, MEM_B, 64'h100, 64'h0, 64'h0, EXC_ACCESS_FAULT, 3, 1, 1);
        repeat (4) @(posedge clk);
        #1;
        force_unalign = 1'b0;

        // Response stalled for 5 cycles while a new request is offered
        bus.rsp_ready_i = 1'b0;
        send(0, MEM_D, 64'h200, 64'h0, 64'h1122_3344_5566_7788, EXC_NONE, 3, 1, 1);
        waited = 0;
        while (!bus.rsp_valid_o && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_wid_i   = MEM_B;
        bus.req_addr_i  = 64'h300;
        bus.req_wdata_i = 64'hEE;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
            chk("stall_rsp_rdata", bus.rsp_rdata_o, 64'h1122_3344_5566_7788);
            chk("stall_rsp_exc", 64'(bus.rsp_exc_o), 64'(EXC_NONE));
            chk("stall_req_ready", 64'(bus.req_ready_o), 64'd0);
            @(posedge clk); #1;
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        // The offered store must not have reached memory
        send(0, MEM_H, 64'h300, 64'h0, 64'hFFFF_FFFF_FFFF_8001, EXC_NONE, 3, 1, 1);

        // Reset during CAPTURE drops the in-flight load
        send(0, MEM_D, 64'h200, 64'h0, 64'h0, EXC_NONE, 3, 1, 0);
        @(posedge clk); #1;
        chk("capt_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("capt_mem_en", 64'(bus.mem_en_o), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("post_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("post_rst_mem_en", 64'(bus.mem_en_o), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle_valid", 64'(bus.rsp_valid_o), 64'd0);
        send(0, MEM_B, 64'h100, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, EXC_NONE, 3, 1, 1);

        // Drain the scoreboard
        waited = 0;
        while (sbq.size() > 0 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (sbq.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
